// File: rtl/rtc_poll_if.sv
// Port bundle between the RTC poll sequencer (master) and the RTC read/write engine (slave).
interface rtc_poll_if;
  logic [7:0] port_id;
  logic [7:0] in_dato;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic [7:0] out_dato;
  logic       flag_done;

  modport master (
    output port_id, in_dato, write_strobe, k_write_strobe, read_strobe,
    input  out_dato, flag_done
  );

  modport slave (
    input  port_id, in_dato, write_strobe, k_write_strobe, read_strobe,
    output out_dato, flag_done
  );
endinterface

// File: rtl/rtc_poll_sequencer.sv
// Autonomous replacement for the soft processor on the RTC engine port bus: issues a transfer
// command plus six register reads per poll and publishes the six BCD bytes as one atomic snapshot.
module rtc_poll_sequencer #(
  parameter int unsigned POLL_CYCLES    = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [7:0]  CMD_PORT       = 8'h0E,
  parameter logic [7:0]  READ_PORT      = 8'h0F,
  parameter logic [7:0]  TRANSFER_CMD   = 8'hF0,
  parameter logic [7:0]  BASE_ADDR      = 8'h21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_req,
  rtc_poll_if.master bus,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       snap_valid,
  output logic       busy,
  output logic       err_timeout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD      = 3'd1;
  localparam logic [2:0] S_CMD_GAP  = 3'd2;
  localparam logic [2:0] S_READ     = 3'd3;
  localparam logic [2:0] S_READ_GAP = 3'd4;
  localparam logic [2:0] S_COMMIT   = 3'd5;

  localparam logic [26:0] POLL_LAST = 27'(POLL_CYCLES - 1);
  localparam logic [9:0]  WAIT_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LAST_IDX  = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [9:0]       wait_cnt;
  logic [26:0]      poll_cnt;
  logic             poll_wrap;
  logic             pending;
  logic             trigger;
  logic             timeout_hit;
  logic [5:0][7:0]  shadow;

  // Deciding on the last strobe cycle lets a flag_done arriving then win over the timeout.
  always_comb begin
    trigger     = poll_wrap | poll_req;
    state_nxt   = state;
    idx_nxt     = idx;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger || pending) begin
          state_nxt = S_CMD;
          idx_nxt   = 3'd0;
        end
      end
      S_CMD: begin
        if (bus.flag_done) begin
          state_nxt = S_CMD_GAP;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_CMD_GAP: state_nxt = S_READ;
      S_READ: begin
        if (bus.flag_done) begin
          state_nxt = S_READ_GAP;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_READ_GAP: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_COMMIT;
        end else begin
          idx_nxt   = idx + 3'd1;
          state_nxt = S_READ;
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Free-running poll timer; the wrap flag is registered and acts as the periodic trigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt  <= '0;
      poll_wrap <= 1'b0;
    end else if (poll_cnt == POLL_LAST) begin
      poll_cnt  <= '0;
      poll_wrap <= 1'b1;
    end else begin
      poll_cnt  <= poll_cnt + 27'd1;
      poll_wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= 3'd0;
      wait_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (state == S_CMD || state == S_READ) begin
        wait_cnt <= wait_cnt + 10'd1;
      end
      // Requests arriving while a poll runs collapse into a single follow-up poll.
      if (state == S_IDLE) begin
        pending <= 1'b0;
      end else if (trigger) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (state == S_READ && bus.flag_done) begin
      shadow[idx] <= bus.out_dato;
    end
  end

  // Outputs are registered from the next state so strobes and bus values change together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.write_strobe   <= 1'b0;
      bus.k_write_strobe <= 1'b0;
      bus.read_strobe    <= 1'b0;
      bus.port_id        <= '0;
      bus.in_dato        <= '0;
      busy               <= 1'b0;
      snap_valid         <= 1'b0;
      err_timeout        <= 1'b0;
      seg                <= '0;
      min                <= '0;
      hora               <= '0;
      dia                <= '0;
      mes                <= '0;
      anio               <= '0;
    end else begin
      bus.write_strobe   <= (state_nxt == S_CMD);
      bus.k_write_strobe <= (state_nxt == S_CMD);
      bus.read_strobe    <= (state_nxt == S_READ);
      if (state_nxt == S_CMD) begin
        bus.port_id <= CMD_PORT;
        bus.in_dato <= TRANSFER_CMD;
      end else if (state_nxt == S_READ) begin
        bus.port_id <= READ_PORT;
        bus.in_dato <= BASE_ADDR + {5'd0, idx_nxt};
      end else begin
        bus.port_id <= '0;
        bus.in_dato <= '0;
      end
      busy        <= (state_nxt != S_IDLE);
      snap_valid  <= (state_nxt == S_COMMIT);
      err_timeout <= timeout_hit;
      if (state_nxt == S_COMMIT) begin
        seg  <= shadow[0];
        min  <= shadow[1];
        hora <= shadow[2];
        dia  <= shadow[3];
        mes  <= shadow[4];
        anio <= shadow[5];
      end
    end
  end

endmodule

// File: tb/tb_rtc_poll_sequencer.sv
// Bench for rtc_poll_sequencer: an RTC engine model answers accesses and queues the expected
// per-poll outcome; a monitor pops and compares on every snap_valid / err_timeout.
module tb_rtc_poll_sequencer;
  localparam int POLL = 50;
  localparam int TMO  = 20;
  localparam logic [47:0] FIXED = 48'h17_05_07_12_30_45;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       poll_req = 1'b0;
  logic [7:0] seg, min, hora, dia, mes, anio;
  logic       snap_valid, busy, err_timeout;
  logic       eng_flag = 1'b0;
  logic       stray_flag = 1'b0;
  logic [7:0] eng_dato = 8'h00;
  logic [47:0] dut_snap;

  rtc_poll_if bus();
  assign bus.flag_done = eng_flag | stray_flag;
  assign bus.out_dato  = eng_dato;
  assign dut_snap      = {anio, mes, dia, hora, min, seg};

  rtc_poll_sequencer #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .poll_req(poll_req), .bus(bus),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .snap_valid(snap_valid), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          to;
    logic [47:0] snap;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] model_snap = '0;
  int          checks = 0;
  int          errors = 0;

  bit eng_rand  = 1'b0;
  bit eng_fixed = 1'b1;
  bit eng_stray = 1'b0;
  int eng_lat   = 4;
  int eng_drop  = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return bus.write_strobe;
      1:       return bus.read_strobe;
      2:       return snap_valid;
      default: return err_timeout;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (sig(which)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Engine model: checks each access, answers after a latency, and predicts each poll's outcome.
  initial begin : engine
    bit          in_acc, gap_chk, dropping;
    int          cnt, lat, acc_n, drop_idx;
    logic [7:0]  held_port, held_dato;
    logic [47:0] data;
    in_acc = 0; gap_chk = 0; dropping = 0;
    cnt = 0; lat = 1; acc_n = 0; drop_idx = 7;
    held_port = '0; held_dato = '0; data = '0;
    forever begin
      @(negedge clk);
      eng_flag = 1'b0;
      if (reset) begin
        in_acc  = 0;
        gap_chk = 0;
        continue;
      end
      if (gap_chk) begin
        gap_chk = 0;
        chk("gap_strobes", 64'({bus.write_strobe, bus.read_strobe}), 64'(2'b00));
        if (eng_stray && $urandom_range(0, 2) == 0) begin
          eng_dato = 8'($urandom);
          eng_flag = 1'b1;
        end
      end else if (!in_acc) begin
        if (bus.write_strobe || bus.read_strobe) begin
          chk("strobe_kind", 64'({bus.write_strobe, bus.k_write_strobe, bus.read_strobe}),
              bus.write_strobe ? 64'(3'b110) : 64'(3'b001));
          if (bus.write_strobe) begin
            acc_n = 0;
            data  = eng_fixed ? FIXED : {16'($urandom), 32'($urandom)};
            if (eng_drop >= 0) begin
              drop_idx = eng_drop;
              eng_drop = -1;
            end else if (eng_rand && $urandom_range(0, 4) == 0) begin
              drop_idx = $urandom_range(0, 6);
            end else begin
              drop_idx = 7;
            end
            if (drop_idx < 7) begin
              exp_q.push_back('{1'b1, model_snap});
            end else begin
              exp_q.push_back('{1'b0, data});
              model_snap = data;
            end
            chk("cmd_bus", 64'({bus.port_id, bus.in_dato}), 64'(16'h0EF0));
          end else begin
            acc_n++;
            chk("read_bus", 64'({bus.port_id, bus.in_dato}), 64'({8'h0F, 8'(8'h20 + acc_n)}));
          end
          in_acc    = 1;
          cnt       = 0;
          dropping  = (acc_n == drop_idx);
          held_port = bus.port_id;
          held_dato = bus.in_dato;
          lat       = eng_rand ? int'($urandom_range(1, 6)) : eng_lat;
        end
      end else begin
        cnt++;
        if (dropping) begin
          if (!(bus.write_strobe || bus.read_strobe) || cnt > TMO + 4) begin
            chk("timeout_strobe_len", 64'(cnt), 64'(TMO));
            in_acc = 0;
          end
        end else begin
          chk("strobe_hold", 64'({bus.write_strobe | bus.read_strobe, bus.port_id, bus.in_dato}),
              64'({1'b1, held_port, held_dato}));
          if (cnt == lat) begin
            eng_flag = 1'b1;
            eng_dato = (acc_n == 0) ? 8'($urandom) : data[8*(acc_n-1) +: 8];
            in_acc   = 0;
            gap_chk  = 1;
          end
        end
      end
    end
  end

  // Monitor: every published result must match the oldest outstanding prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (snap_valid || err_timeout)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'({snap_valid, err_timeout}), 64'(2'b00));
        end else begin
          e = exp_q.pop_front();
          chk("output_kind", 64'({snap_valid, err_timeout}), e.to ? 64'(2'b01) : 64'(2'b10));
          chk("snapshot", 64'(dut_snap), 64'(e.snap));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, n2;
    bit ok;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_ctrl", 64'({bus.write_strobe, bus.k_write_strobe, bus.read_strobe, busy, snap_valid, err_timeout}), 64'(0));
    chk("reset_bus", 64'({bus.port_id, bus.in_dato}), 64'(0));
    chk("reset_snapshot", 64'(dut_snap), 64'(0));

    // Fixed-data poll after the first timer wrap.
    wait_for(0, 200, n, ok);
    chk("first_cmd_seen", 64'(ok), 64'(1));
    chk("first_cmd_delay", 64'(n), 64'(POLL + 1));
    wait_for(2, 200, n, ok);
    chk("first_snap_seen", 64'(ok), 64'(1));
    chk("first_snap_values", 64'(dut_snap), 64'(FIXED));

    // Third read never answered.
    eng_drop = 3;
    wait_for(3, 300, n, ok);
    chk("timeout_seen", 64'(ok), 64'(1));
    chk("timeout_snap_kept", 64'(dut_snap), 64'(FIXED));
    @(negedge clk);
    chk("after_timeout", 64'({busy, err_timeout, bus.write_strobe, bus.read_strobe}), 64'(0));

    // Zero-wait engine; three manual requests during a poll give exactly one follow-up poll.
    eng_lat   = 1;
    eng_fixed = 1'b0;
    wait_for(0, 200, n, ok);
    chk("pend_first_cmd", 64'(ok), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); poll_req = 1'b1;
      @(negedge clk); poll_req = 1'b0;
    end
    wait_for(2, 100, n, ok);
    chk("pend_first_snap", 64'(ok), 64'(1));
    chk("min_latency", 64'(n + 6), 64'(21));
    wait_for(0, 10, n2, ok);
    chk("pend_second_cmd", 64'(ok), 64'(1));
    chk("pend_second_delay", 64'(n2), 64'(2));
    wait_for(2, 100, n, ok);
    chk("pend_second_snap", 64'(ok), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stray_flag = (i == 0);
      chk("no_extra_poll", 64'({busy, bus.write_strobe, bus.read_strobe}), 64'(0));
      chk("stray_idle_snap", 64'(dut_snap), 64'(model_snap));
    end
    stray_flag = 1'b0;

    // Randomized traffic: latencies, dropped accesses, manual requests, stray done pulses.
    eng_rand  = 1'b1;
    eng_stray = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      poll_req   = ($urandom_range(0, 59) == 0);
      stray_flag = (!busy && $urandom_range(0, 19) == 0);
    end
    poll_req   = 1'b0;
    stray_flag = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset in the middle of a read.
    eng_rand  = 1'b0;
    eng_stray = 1'b0;
    eng_lat   = 10;
    wait_for(1, 300, n, ok);
    chk("read_before_reset", 64'(ok), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_reset_ctrl", 64'({bus.write_strobe, bus.k_write_strobe, bus.read_strobe, busy}), 64'(0));
    chk("async_reset_snap", 64'(dut_snap), 64'(0));
    exp_q.delete();
    model_snap = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_for(2, 300, n, ok);
    chk("post_reset_snap", 64'(ok), 64'(1));
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
